// File: rtl/axi_req_arb_queue.sv
// AXI AR/AW ingress: round-robin arbitration into a show-ahead request queue,
// with a registered downstream AR slot. Define REQ_STATS_EN for grant/stall counters.
module axi_req_arb_queue #(
    parameter int unsigned ID_W      = 16,
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AEMPTY_TH = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ID_W-1:0]            arid_i,
    input  logic [ADDR_W-1:0]          araddr_i,
    input  logic [LEN_W-1:0]           arlen_i,
    input  logic                       arvalid_i,
    output logic                       arready_o,
    input  logic [ID_W-1:0]            awid_i,
    input  logic [ADDR_W-1:0]          awaddr_i,
    input  logic [LEN_W-1:0]           awlen_i,
    input  logic                       awvalid_i,
    output logic                       awready_o,
    output logic [ID_W-1:0]            arid_o,
    output logic [ADDR_W-1:0]          araddr_o,
    output logic [LEN_W-1:0]           arlen_o,
    output logic                       arvalid_o,
    input  logic                       arready_i,
    output logic                       aempty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    input  logic                       rden_i,
    output logic [ID_W+ADDR_W:0]       data_o
`ifdef REQ_STATS_EN
    ,
    output logic [31:0]                rd_acc_o,
    output logic [31:0]                wr_acc_o,
    output logic [31:0]                stall_o
`endif
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH+1);
    localparam int unsigned DATA_W = 1 + ID_W + ADDR_W;

    typedef enum logic {
        RR_AR,
        RR_AW
    } rr_t;

    rr_t               rr_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic              slot_free;
    logic              rd_ok;
    logic              wr_ok;
    logic              grant_rd;
    logic              grant_wr;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_data;
    logic              unused_awlen;

    // Write length is not carried anywhere downstream of this block.
    assign unused_awlen = ^awlen_i;

    assign full_o    = (count_o == CNT_W'(DEPTH));
    assign aempty_o  = (count_o <= CNT_W'(AEMPTY_TH));
    assign slot_free = !arvalid_o || arready_i;
    assign rd_ok     = arvalid_i && !full_o && slot_free;
    assign wr_ok     = awvalid_i && !full_o;

    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (rd_ok && wr_ok) begin
            grant_rd = (rr_q == RR_AR);
            grant_wr = (rr_q == RR_AW);
        end else begin
            grant_rd = rd_ok;
            grant_wr = wr_ok;
        end
    end

    assign arready_o = grant_rd;
    assign awready_o = grant_wr;
    assign push      = grant_rd || grant_wr;
    // Full is judged on the pre-pop count, so push and pop never coincide at full.
    assign pop       = rden_i && (count_o != '0);
    assign push_data = grant_wr ? {1'b1, awid_i, awaddr_i} : {1'b0, arid_i, araddr_i};
    assign data_o    = (count_o != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= RR_AR;
        end else if (rd_ok && wr_ok) begin
            rr_q <= (rr_q == RR_AR) ? RR_AW : RR_AR;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count_o <= count_o + CNT_W'(1);
            end else if (pop && !push) begin
                count_o <= count_o - CNT_W'(1);
            end
        end
    end

    // A grant can only occur when the slot is free, so a reload wins over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arvalid_o <= 1'b0;
            arid_o    <= '0;
            araddr_o  <= '0;
            arlen_o   <= '0;
        end else if (grant_rd) begin
            arvalid_o <= 1'b1;
            arid_o    <= arid_i;
            araddr_o  <= araddr_i;
            arlen_o   <= arlen_i;
        end else if (arready_i) begin
            arvalid_o <= 1'b0;
        end
    end

`ifdef REQ_STATS_EN
    logic stall;

    assign stall = (arvalid_i || awvalid_i) && !push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_acc_o <= '0;
            wr_acc_o <= '0;
            stall_o  <= '0;
        end else begin
            if (grant_rd && (rd_acc_o != '1)) begin
                rd_acc_o <= rd_acc_o + 32'd1;
            end
            if (grant_wr && (wr_acc_o != '1)) begin
                wr_acc_o <= wr_acc_o + 32'd1;
            end
            if (stall && (stall_o != '1)) begin
                stall_o <= stall_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axi_req_arb_queue.sv
// Scoreboard bench for axi_req_arb_queue: directed scenarios plus random traffic.
module tb_axi_req_arb_queue;

    localparam int unsigned ID_W      = 16;
    localparam int unsigned ADDR_W    = 64;
    localparam int unsigned LEN_W     = 8;
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned AEMPTY_TH = 1;
    localparam int unsigned CNT_W     = $clog2(DEPTH+1);
    localparam int unsigned DATA_W    = 1 + ID_W + ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [LEN_W-1:0]  arlen;
    logic              arvalid;
    logic              arready_o;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [LEN_W-1:0]  awlen;
    logic              awvalid;
    logic              awready_o;
    logic [ID_W-1:0]   arid_o;
    logic [ADDR_W-1:0] araddr_o;
    logic [LEN_W-1:0]  arlen_o;
    logic              arvalid_o;
    logic              arready_in;
    logic              aempty_o;
    logic              full_o;
    logic [CNT_W-1:0]  count_o;
    logic              rden;
    logic [DATA_W-1:0] data_o;
`ifdef REQ_STATS_EN
    logic [31:0]       rd_acc_o;
    logic [31:0]       wr_acc_o;
    logic [31:0]       stall_o;
`endif

    axi_req_arb_queue #(
        .ID_W      (ID_W),
        .ADDR_W    (ADDR_W),
        .LEN_W     (LEN_W),
        .DEPTH     (DEPTH),
        .AEMPTY_TH (AEMPTY_TH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arid_i    (arid),
        .araddr_i  (araddr),
        .arlen_i   (arlen),
        .arvalid_i (arvalid),
        .arready_o (arready_o),
        .awid_i    (awid),
        .awaddr_i  (awaddr),
        .awlen_i   (awlen),
        .awvalid_i (awvalid),
        .awready_o (awready_o),
        .arid_o    (arid_o),
        .araddr_o  (araddr_o),
        .arlen_o   (arlen_o),
        .arvalid_o (arvalid_o),
        .arready_i (arready_in),
        .aempty_o  (aempty_o),
        .full_o    (full_o),
        .count_o   (count_o),
        .rden_i    (rden),
        .data_o    (data_o)
`ifdef REQ_STATS_EN
        ,
        .rd_acc_o  (rd_acc_o),
        .wr_acc_o  (wr_acc_o),
        .stall_o   (stall_o)
`endif
    );

    always #5 clk = ~clk;

    int unsigned       n_checks = 0;
    int unsigned       n_fail   = 0;

    // Reference model state
    logic [DATA_W-1:0] sb[$];
    bit                m_rr;
    bit                m_sv;
    logic [ID_W-1:0]   m_sid;
    logic [ADDR_W-1:0] m_saddr;
    logic [LEN_W-1:0]  m_slen;
    int unsigned       m_rd_acc, m_wr_acc, m_stall;

    logic              obs_ar, obs_aw;
    logic [DATA_W-1:0] obs_data;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_rr     = 1'b0;
        m_sv     = 1'b0;
        m_sid    = '0;
        m_saddr  = '0;
        m_slen   = '0;
        m_rd_acc = 0;
        m_wr_acc = 0;
        m_stall  = 0;
    endtask

    task automatic idle_inputs();
        arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
        arready_in = 1'b0; rden = 1'b0;
    endtask

    // Called at posedge+1 with inputs set; checks this cycle, advances the model over the edge.
    task automatic tick();
        bit full, sf, rok, wok, grd, gwr;
        logic [DATA_W-1:0] head;
        #1;
        full = (sb.size() == DEPTH);
        sf   = !m_sv || arready_in;
        rok  = arvalid && !full && sf;
        wok  = awvalid && !full;
        grd  = rok && (!wok || !m_rr);
        gwr  = wok && (!rok || m_rr);
        head = (sb.size() > 0) ? sb[0] : '0;
        obs_ar   = arready_o;
        obs_aw   = awready_o;
        obs_data = data_o;
        chk("arready", arready_o, grd);
        chk("awready", awready_o, gwr);
        chk("count", count_o, sb.size());
        chk("full", full_o, full);
        chk("aempty", aempty_o, sb.size() <= AEMPTY_TH);
        chk("data", data_o, head);
        chk("arvalid_o", arvalid_o, m_sv);
        if (m_sv) begin
            chk("arid_o", arid_o, m_sid);
            chk("araddr_o", araddr_o, m_saddr);
            chk("arlen_o", arlen_o, m_slen);
        end
        @(posedge clk);
        #1;
        if (rden && sb.size() > 0) void'(sb.pop_front());
        if (grd) sb.push_back({1'b0, arid, araddr});
        if (gwr) sb.push_back({1'b1, awid, awaddr});
        if (grd) begin
            m_sv = 1'b1; m_sid = arid; m_saddr = araddr; m_slen = arlen;
        end else if (arready_in) begin
            m_sv = 1'b0;
        end
        if (rok && wok) m_rr = !m_rr;
        if (grd && m_rd_acc != 32'hFFFF_FFFF) m_rd_acc++;
        if (gwr && m_wr_acc != 32'hFFFF_FFFF) m_wr_acc++;
        if ((arvalid || awvalid) && !grd && !gwr && m_stall != 32'hFFFF_FFFF) m_stall++;
    endtask

    task automatic drain();
        idle_inputs();
        arready_in = 1'b1;
        rden = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) tick();
        rden = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #3;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        chk("rst_count", count_o, 0);
        chk("rst_aempty", aempty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_arvalid", arvalid_o, 0);
        chk("rst_araddr", araddr_o, 0);
        chk("rst_data", data_o, 0);

        // Single read
        arid = 16'd5; araddr = 64'h1000; arlen = 8'd3; arvalid = 1'b1; arready_in = 1'b1;
        tick();
        chk("rd1_grant", obs_ar, 1);
        arvalid = 1'b0;
        chk("rd1_arvalid_o", arvalid_o, 1);
        chk("rd1_araddr_o", araddr_o, 64'h1000);
        chk("rd1_arlen_o", arlen_o, 3);
        chk("rd1_data", data_o, {1'b0, 16'd5, 64'h1000});
        chk("rd1_count", count_o, 1);
        tick();
        chk("rd1_one_cycle", obs_ar, 0);
        drain();

        // Contested: R,W,R,W
        arvalid = 1'b1; awvalid = 1'b1; arready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            arid = 16'(i); araddr = 64'h2000 + 64'(i);
            awid = 16'(i + 8); awaddr = 64'h3000 + 64'(i);
            tick();
            chk("alt_ar", obs_ar, (i % 2) == 0);
            chk("alt_aw", obs_aw, (i % 2) == 1);
        end
        arvalid = 1'b0; awvalid = 1'b0;
        rden = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("alt_pop_iswr", obs_data[DATA_W-1], (i % 2) == 1);
        end
        drain();

        // Fill to full with writes
        awvalid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            awid = 16'(i); awaddr = 64'h8000 + 64'(i * 64);
            tick();
        end
        chk("full_count", count_o, DEPTH);
        chk("full_flag", full_o, 1);
        awid = 16'h77; awaddr = 64'hDEAD;
        tick();
        chk("full_reject", obs_aw, 0);
        rden = 1'b1;
        tick();
        chk("full_pop_noacc", obs_aw, 0);
        chk("full_pop_count", count_o, DEPTH - 1);
        rden = 1'b0;
        tick();
        chk("full_late_acc", obs_aw, 1);
        chk("full_refill", count_o, DEPTH);
        drain();

        // Downstream backpressure
        arready_in = 1'b0; arvalid = 1'b1; arid = 16'h11; araddr = 64'h4000; arlen = 8'd7;
        tick();
        araddr = 64'h5000; arid = 16'h22; arlen = 8'd1;
        tick();
        chk("bp_block", obs_ar, 0);
        tick();
        chk("bp_hold_addr", araddr_o, 64'h4000);
        chk("bp_hold_valid", arvalid_o, 1);
        arready_in = 1'b1;
        tick();
        chk("bp_accept", obs_ar, 1);
        chk("bp_reload", araddr_o, 64'h5000);
        chk("bp_reload_id", arid_o, 16'h22);
        drain();

        // Pop on empty
        rden = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("empty_pop_count", count_o, 0);
        rden = 1'b0;

        // Random traffic, wraps pointers many times
        for (int i = 0; i < 400; i++) begin
            arvalid    = 1'($urandom_range(0, 1));
            awvalid    = 1'($urandom_range(0, 1));
            arready_in = ($urandom_range(0, 3) != 0);
            rden       = ($urandom_range(0, 2) != 0) ? (i % 64 < 40) : 1'b0;
            arid   = 16'($urandom); araddr = {32'($urandom), 32'($urandom)}; arlen = 8'($urandom);
            awid   = 16'($urandom); awaddr = {32'($urandom), 32'($urandom)}; awlen = 8'($urandom);
            tick();
        end

`ifdef REQ_STATS_EN
        chk("stat_rd", rd_acc_o, m_rd_acc);
        chk("stat_wr", wr_acc_o, m_wr_acc);
        chk("stat_stall", stall_o, m_stall);
`endif

        // Asynchronous reset mid-operation
        idle_inputs();
        awvalid = 1'b1; arvalid = 1'b1; arready_in = 1'b0; awaddr = 64'hAA; araddr = 64'hBB;
        for (int i = 0; i < 3; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", count_o, 0);
        chk("mid_rst_arvalid", arvalid_o, 0);
        chk("mid_rst_data", data_o, 0);
        chk("mid_rst_aempty", aempty_o, 1);
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            arvalid    = 1'($urandom_range(0, 1));
            awvalid    = 1'($urandom_range(0, 1));
            arready_in = 1'($urandom_range(0, 1));
            rden       = 1'($urandom_range(0, 1));
            arid = 16'($urandom); araddr = 64'($urandom); arlen = 8'($urandom);
            awid = 16'($urandom); awaddr = 64'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
